seq_detector_p: RTL and testbench

- Parametrised serial bit-pattern detector; next generation of the single-pattern `sel`→`flag` detector.
- Accepts one serial bit per qualified clock on `sel`.
- Compares the last PAT_W accepted bits against a runtime-loaded pattern and pulses `flag` on a match.
- Supports overlapping or non-overlapping detection and keeps a saturating match count; sits behind the serial stimulus interface in the demo testbench.

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/sat_counter.sv | 27 ++
 rtl/seq_detector_p.sv | 129 ++++++++++++
 tb/tb_seq_detector_p.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the seq_detector_p serial pattern detector.
package seq_det_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_PAT_W = 32;

    // FILL: history not yet complete; ARMED: every accepted bit is compared.
    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } seq_det_state_e;

    // Masked compare; callers zero-extend their PAT_W-wide operands.
    function automatic logic pat_match(input logic [MAX_PAT_W-1:0] hist,
                                       input logic [MAX_PAT_W-1:0] pat,
                                       input logic [MAX_PAT_W-1:0] mask);
        return ((hist ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a synchronous clear takes priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count register: clear wins, otherwise increment until all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_p.sv
// Serial bit-pattern detector with runtime-loadable pattern, overlap mode
// and a saturating match counter. Optional macro SEQ_DET_MASK_EN adds a
// per-bit don't-care mask (cfg_mask) latched together with the pattern.
module seq_detector_p
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1011),
    parameter logic             RST_OVL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             sel_vld,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] cfg_mask,
`endif
    input  logic             cfg_overlap,
    input  logic             clr_cnt,
    output logic             flag,
    output logic             armed,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    seq_det_state_e    state_q, state_d;
    logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  mask_w;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
    logic              ovl_q, ovl_d;
    logic              flag_q, flag_d;
    logic              match;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0]  mask_q, mask_d;
    assign mask_w = mask_q;
`else
    assign mask_w = '1;
`endif

    // Next-state, history and match evaluation for one accepted bit.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        pat_d      = pat_q;
        ovl_d      = ovl_q;
        flag_d     = 1'b0;
        match      = 1'b0;
`ifdef SEQ_DET_MASK_EN
        mask_d     = mask_q;
`endif
        hist_shift = {hist_q[PAT_W-2:0], sel};
        fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

        if (cfg_load) begin
            // A load restarts detection; the bit offered this cycle is dropped.
            pat_d   = cfg_pattern;
            ovl_d   = cfg_overlap;
`ifdef SEQ_DET_MASK_EN
            mask_d  = cfg_mask;
`endif
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (sel_vld) begin
            match  = (fill_inc == FILL_FULL) &&
                     pat_match(MAX_PAT_W'(hist_shift), MAX_PAT_W'(pat_q), MAX_PAT_W'(mask_w));
            flag_d = match;
            if (match && !ovl_q) begin
                // Non-overlapping: the next match needs PAT_W fresh bits.
                hist_d  = '0;
                fill_d  = '0;
                state_d = FILL;
            end else begin
                hist_d  = hist_shift;
                fill_d  = fill_inc;
                state_d = (fill_inc == FILL_FULL) ? ARMED : FILL;
            end
        end
    end

    // State, history, configuration and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= RST_PAT;
            ovl_q   <= RST_OVL;
            flag_q  <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            mask_q  <= '1;
`endif
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            flag_q  <= flag_d;
`ifdef SEQ_DET_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match),
        .clr   (clr_cnt),
        .count (match_cnt)
    );

    assign flag  = flag_q;
    assign armed = (state_q == ARMED);

endmodule

// File: tb/tb_seq_detector_p.sv
// Self-checking bench for seq_detector_p: a default instance and a CNT_W=2
// instance share stimulus; expected outputs are queued per driven cycle and
// compared one cycle later. Define SEQ_DET_MASK_EN to also exercise cfg_mask.
module tb_seq_detector_p;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic       sel_vld;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic       cfg_overlap;
    logic       clr_cnt;
    logic       flag, armed;
    logic [7:0] match_cnt;
    logic       flag2, armed2;
    logic [1:0] match_cnt2;
`ifdef SEQ_DET_MASK_EN
    logic [3:0] cfg_mask;
`endif

    typedef struct packed {
        logic       flag;
        logic       armed;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_cnt8;
    logic [1:0] m_cnt2;
    int         n_tests;
    int         n_fail;

    seq_detector_p u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel         (sel),
        .sel_vld     (sel_vld),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask    (cfg_mask),
`endif
        .cfg_overlap (cfg_overlap),
        .clr_cnt     (clr_cnt),
        .flag        (flag),
        .armed       (armed),
        .match_cnt   (match_cnt)
    );

    seq_detector_p #(
        .CNT_W (2)
    ) u_dut_c2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel         (sel),
        .sel_vld     (sel_vld),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask    (cfg_mask),
`endif
        .cfg_overlap (cfg_overlap),
        .clr_cnt     (clr_cnt),
        .flag        (flag2),
        .armed       (armed2),
        .match_cnt   (match_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic drive(input string tag, input logic vld, input logic b, input logic load,
                         input logic clr, input logic eflag, input logic earmed);
        exp_t e;
        sel_vld  = vld;
        sel      = vld ? b : 1'bx;
        cfg_load = load;
        clr_cnt  = clr;
        if (clr) begin
            m_cnt8 = '0;
            m_cnt2 = '0;
        end else if (eflag) begin
            if (m_cnt8 != 8'hff) m_cnt8 = m_cnt8 + 1'b1;
            if (m_cnt2 != 2'h3)  m_cnt2 = m_cnt2 + 1'b1;
        end
        e.flag  = eflag;
        e.armed = earmed;
        e.cnt   = m_cnt8;
        e.cnt2  = m_cnt2;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        sel_vld  = 1'b0;
        sel      = 1'bx;
        cfg_load = 1'b0;
        clr_cnt  = 1'b0;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_flag"},  {31'd0, flag},       {31'd0, e.flag});
            check({tag, "_armed"}, {31'd0, armed},      {31'd0, e.armed});
            check({tag, "_cnt"},   {24'd0, match_cnt},  {24'd0, e.cnt});
            check({tag, "_flag2"}, {31'd0, flag2},      {31'd0, e.flag});
            check({tag, "_cnt2"},  {30'd0, match_cnt2}, {30'd0, e.cnt2});
        end
    endtask

    // Replay a stimulus table, MSB first.
    task automatic run_seq(input string tag, input int n, input logic [15:0] vld,
                           input logic [15:0] bits, input logic [15:0] flg, input logic [15:0] arm);
        for (int i = n - 1; i >= 0; i--) begin
            drive($sformatf("%s[%0d]", tag, n - 1 - i), vld[i], bits[i], 1'b0, 1'b0, flg[i], arm[i]);
        end
    endtask

    task automatic do_load(input string tag, input logic [3:0] pat, input logic [3:0] mask,
                           input logic ovl, input logic vld, input logic b);
        cfg_pattern = pat;
        cfg_overlap = ovl;
`ifdef SEQ_DET_MASK_EN
        cfg_mask    = mask;
`else
        if (mask != 4'hf) $display("note: mask %0h ignored in this build", mask);
`endif
        drive(tag, vld, b, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        check({tag, "_rst_flag"},  {31'd0, flag},       32'd0);
        check({tag, "_rst_armed"}, {31'd0, armed},      32'd0);
        check({tag, "_rst_cnt"},   {24'd0, match_cnt},  32'd0);
        check({tag, "_rst_cnt2"},  {30'd0, match_cnt2}, 32'd0);
        check({tag, "_rst_nox"},   {31'd0, $isunknown({flag, armed, match_cnt})}, 32'd0);
        m_cnt8 = '0;
        m_cnt2 = '0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        m_cnt8      = '0;
        m_cnt2      = '0;
        rst_n       = 1'b0;
        sel         = 1'b0;
        sel_vld     = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = 4'h0;
        cfg_overlap = 1'b0;
        clr_cnt     = 1'b0;
`ifdef SEQ_DET_MASK_EN
        cfg_mask    = 4'hf;
`endif
        #1;
        do_reset("init");

        // 1: overlapping detection of 1011 in 1,0,1,1,0,1,1.
        run_seq("t1", 7, 16'h007f, 16'h005b, 16'h0009, 16'h000f);
        check("t1_total", {24'd0, match_cnt}, 32'd2);
        drive("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 2: non-overlapping; only the first 1011 counts, armed drops after it.
        do_load("t2_load", 4'b1011, 4'hf, 1'b0, 1'b0, 1'b0);
        run_seq("t2", 7, 16'h007f, 16'h005b, 16'h0008, 16'h0000);
        check("t2_total", {24'd0, match_cnt}, 32'd3);

        // 3: gaps with sel = X do not disturb the history.
        do_load("t3_load", 4'b1011, 4'hf, 1'b1, 1'b0, 1'b0);
        run_seq("t3", 8, 16'h00c9, 16'h0089, 16'h0001, 16'h0001);
        drive("t3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 4: bit offered with cfg_load is dropped; match needs four more 1s.
        do_load("t4_load", 4'b1111, 4'hf, 1'b1, 1'b1, 1'b1);
        run_seq("t4", 4, 16'h000f, 16'h000f, 16'h0001, 16'h0001);

        // 5: saturation on the 2-bit counter, then clear during a match.
        do_reset("t5");
        do_load("t5_load", 4'b1111, 4'hf, 1'b1, 1'b0, 1'b0);
        run_seq("t5", 8, 16'h00ff, 16'h00ff, 16'h001f, 16'h001f);
        check("t5_sat2", {30'd0, match_cnt2}, 32'd3);
        check("t5_cnt8", {24'd0, match_cnt},  32'd5);
        drive("t5_clr",  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        drive("t5_next", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        // 6: reset mid-pattern discards history and restores pattern 1011.
        do_reset("t6a");
        run_seq("t6a", 3, 16'h0007, 16'h0005, 16'h0000, 16'h0000);
        do_reset("t6b");
        run_seq("t6b", 4, 16'h000f, 16'h000b, 16'h0001, 16'h0001);

`ifdef SEQ_DET_MASK_EN
        // Mask 1101 makes bit 1 a don't-care: 1001 matches pattern 1011.
        do_load("mask_load", 4'b1011, 4'b1101, 1'b1, 1'b0, 1'b0);
        run_seq("mask", 4, 16'h000f, 16'h0009, 16'h0001, 16'h0001);
`endif

        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
